dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - port 0: the core load/store path (ALU address, rs2 write data).
  - port 1: a DMA/debug loader.
- Port 0 has fixed priority. A starvation counter forces a port-1 grant after a bounded wait.
- One access per cycle. Memory write is synchronous and memory read is combinational. The block registers read data, so requesters see it one cycle after grant.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core (port 0) has fixed priority,
// a starvation counter forces a DMA (port 1) grant. Optional bus locking: DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        wait_cnt_reg;
  logic              rvalid0_reg;
  logic              rvalid1_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              force1;
  logic              gnt0_arb;
  logic              gnt1_arb;
  logic              gnt0_int;
  logic              gnt1_int;
  logic              read_any;
  logic [3:0]        wait_cnt_next;

`ifdef DMEM_ARB_LOCK_EN
  logic owner_valid_reg;
  logic owner_reg;
  logic owner_req;
  logic owner_gnt;
  logic owner_lock;
`endif

  always_comb begin
    force1   = req1 && (wait_cnt_reg == LIMIT);
    gnt1_arb = req1 && (!req0 || force1);
    gnt0_arb = req0 && !gnt1_arb;
`ifdef DMEM_ARB_LOCK_EN
    // A locked owner excludes the other port, overriding priority and starvation.
    if (owner_valid_reg) begin
      gnt0_arb = req0 && !owner_reg;
      gnt1_arb = req1 && owner_reg;
    end
`endif
    gnt0_int = reset && gnt0_arb;
    gnt1_int = reset && gnt1_arb;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0_int) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1_int) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_comb begin
    read_any = (gnt0_int && !we0) || (gnt1_int && !we1);
    if (req1 && !gnt1_int) begin
      wait_cnt_next = (wait_cnt_reg >= LIMIT) ? LIMIT : wait_cnt_reg + 4'd1;
    end else begin
      wait_cnt_next = 4'd0;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  always_comb begin
    owner_req  = owner_reg ? req1 : req0;
    owner_gnt  = owner_reg ? gnt1_int : gnt0_int;
    owner_lock = owner_reg ? lock1 : lock0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_reg <= 4'd0;
      rvalid0_reg  <= 1'b0;
      rvalid1_reg  <= 1'b0;
      rdata_reg    <= '0;
`ifdef DMEM_ARB_LOCK_EN
      owner_valid_reg <= 1'b0;
      owner_reg       <= 1'b0;
`endif
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      rvalid0_reg  <= gnt0_int && !we0;
      rvalid1_reg  <= gnt1_int && !we1;
      if (read_any) begin
        rdata_reg <= mem_rdata;
      end
`ifdef DMEM_ARB_LOCK_EN
      if (owner_valid_reg) begin
        if (!owner_req || (owner_gnt && !owner_lock)) begin
          owner_valid_reg <= 1'b0;
        end
      end else if (gnt0_int && lock0) begin
        owner_valid_reg <= 1'b1;
        owner_reg       <= 1'b0;
      end else if (gnt1_int && lock1) begin
        owner_valid_reg <= 1'b1;
        owner_reg       <= 1'b1;
      end
`endif
    end
  end

  assign gnt0    = gnt0_int;
  assign gnt1    = gnt1_int;
  assign rvalid0 = rvalid0_reg;
  assign rvalid1 = rvalid1_reg;
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed test-plan steps then randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          lock0, lock1;
  int            m_own;
`endif

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  int n_cmp = 0;
  int n_mis = 0;

  // reference-model state
  int            m_wait;
  logic          m_rv0, m_rv1;
  logic [DW-1:0] m_rdata;
  logic          e_g0, e_g1, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic          obs_g0, obs_g1, obs_we;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wd;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
`ifdef DMEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check combinational outputs, clock, check registers.
  task automatic cycle();
    #1;
    if (!reset) begin
      e_g0 = 1'b0;
      e_g1 = 1'b0;
    end else begin
      // port 1 wins when core is idle or after it has waited LIMIT cycles
      e_g1 = req1 && (!req0 || m_wait >= LIMIT);
      e_g0 = req0 && !e_g1;
`ifdef DMEM_ARB_LOCK_EN
      if (m_own == 0) begin e_g0 = req0; e_g1 = 1'b0; end
      if (m_own == 1) begin e_g1 = req1; e_g0 = 1'b0; end
`endif
    end
    e_we   = (e_g0 && we0) || (e_g1 && we1);
    e_addr = e_g0 ? addr0 : (e_g1 ? addr1 : '0);
    e_wd   = e_g0 ? wdata0 : (e_g1 ? wdata1 : '0);
    obs_g0 = gnt0; obs_g1 = gnt1; obs_we = mem_we; obs_addr = mem_addr; obs_wd = mem_wdata;
    chk("gnt0", 32'(gnt0), 32'(e_g0));
    chk("gnt1", 32'(gnt1), 32'(e_g1));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    if (reset) chk("wait_cnt", 32'(dut.wait_cnt_reg), 32'(m_wait));
    @(posedge clk);
    if (obs_we) mem[obs_addr[7:0]] = obs_wd;
    if (!reset) begin
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0; m_wait = 0;
`ifdef DMEM_ARB_LOCK_EN
      m_own = -1;
`endif
    end else begin
      m_rv0 = e_g0 && !we0;
      m_rv1 = e_g1 && !we1;
      if (m_rv0 || m_rv1) m_rdata = ref_mem[e_addr[7:0]];
      if (e_we) ref_mem[e_addr[7:0]] = e_wd;
      m_wait = (req1 && !e_g1) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
`ifdef DMEM_ARB_LOCK_EN
      if (m_own == 0) begin
        if (!req0 || (e_g0 && !lock0)) m_own = -1;
      end else if (m_own == 1) begin
        if (!req1 || (e_g1 && !lock1)) m_own = -1;
      end else if (e_g0 && lock0) m_own = 0;
      else if (e_g1 && lock1) m_own = 1;
`endif
    end
    #1;
    chk("rvalid0", 32'(rvalid0), 32'(m_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(m_rv1));
    chk("rdata", rdata, m_rdata);
    @(negedge clk);
  endtask

  initial begin : stim
    logic [9:0] pat;
    bit         pend0, pend1, seen;
    logic [DW-1:0] v;

    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    m_wait = 0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0;
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
`ifdef DMEM_ARB_LOCK_EN
    lock0 = 0; lock1 = 0; m_own = -1;
`endif
    @(negedge clk);

    // reset: request held but nothing may be granted
    req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'h0BAD0BAD;
    cycle(); cycle();
    chk("reset_rdata", rdata, 32'h0);
    req0 = 0; we0 = 0; reset = 1'b1;
    cycle();

    // port 0 read alone
    req0 = 1; we0 = 0; addr0 = 32'h10;
    cycle();
    chk("tp_read_gnt0", 32'(obs_g0), 32'd1);
    chk("tp_read_data", rdata, 32'hDEADBEEF);
    req0 = 0;

    // port 1 write alone, then port 0 reads it back
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
    cycle();
    chk("tp_write_gnt1", 32'(obs_g1), 32'd1);
    req1 = 0;
    req0 = 1; we0 = 0; addr0 = 32'h20;
    cycle();
    chk("tp_readback", rdata, 32'h12345678);
    req0 = 0;
    cycle();

    // starvation: both held for ten cycles
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h20;
    for (int i = 0; i < 10; i++) begin
      cycle();
      pat[i] = obs_g1;
    end
    chk("tp_starve_pattern", 32'(pat), 32'b10_0001_0000);
    req0 = 0; req1 = 0;
    cycle();

    // contention then release: req0 drops in cycle 2
    req0 = 1; req1 = 1; we1 = 1; addr1 = 32'h24; wdata1 = 32'hCAFEF00D;
    cycle(); cycle();
    req0 = 0;
    cycle();
    chk("tp_release_gnt1", 32'(obs_g1), 32'd1);
    req1 = 0;
    cycle();
    chk("tp_release_wait", 32'(dut.wait_cnt_reg), 32'd0);

    // reset right after a granted read
    req0 = 1; we0 = 0; addr0 = 32'h10;
    cycle();
    reset = 1'b0; addr0 = 32'h20;
    cycle();
    chk("tp_rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("tp_rst_rdata", rdata, 32'h0);
    cycle();
    reset = 1'b1;
    cycle();
    chk("tp_rst_first_gnt", 32'(obs_g0), 32'd1);
    req0 = 0;
    cycle();

`ifdef DMEM_ARB_LOCK_EN
    // locked read-modify-write by port 1 while the core keeps requesting
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h30; lock1 = 1;
    seen = 0;
    for (int i = 0; i < LIMIT + 2 && !seen; i++) begin
      cycle();
      seen = obs_g1;
    end
    chk("tp_lock_first", 32'(seen), 32'd1);
    we1 = 1; lock1 = 0; wdata1 = 32'hA5A5A5A5;
    cycle();
    chk("tp_lock_gnt1", 32'(obs_g1), 32'd1);
    chk("tp_lock_gnt0", 32'(obs_g0), 32'd0);
    req1 = 0;
    cycle();
    chk("tp_lock_after", 32'(obs_g0), 32'd1);
    req0 = 0;
    cycle();
`endif

    // randomized traffic with handshake-respecting requesters
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1; we0 = 1'($urandom); addr0 = 32'($urandom_range(0, 15)); wdata0 = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1; we1 = 1'($urandom); addr1 = 32'($urandom_range(0, 15)); wdata1 = $urandom;
      end else if (pend1 && $urandom_range(0, 11) == 0) begin
        pend1 = 0;
      end
      req0 = pend0; req1 = pend1;
      reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      cycle();
      if (e_g0) pend0 = 0;
      if (e_g1) pend1 = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
